// File: rtl/mimosa_host_if.sv
// Host-side interface to the mimosa pet core: heartbeat generation, timed stimulus pulses,
// filtered emotion read-back and permanent death detection.
module mimosa_host_if #(
    parameter int unsigned HB_DIV        = 4,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned PULSE_BEATS   = 2,
    parameter int unsigned DEAD_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hb_en,
    output logic       heartbeat,
    input  logic       stim_req,
    input  logic [6:0] stim_code,
    output logic       stim_ack,
    output logic       stim_busy,
    output logic [6:0] stim_out,
    input  logic [7:0] emotion_in,
    input  logic       model_clk_in,
    output logic [7:0] emotion_out,
    output logic       emotion_evt,
    output logic       dead_out
);

    localparam int unsigned HW = $clog2(HB_DIV);
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned BW = $clog2(PULSE_BEATS) + 1;
    localparam int unsigned DW = $clog2(DEAD_TIMEOUT + 1);

    localparam logic [HW-1:0] HB_LAST   = HW'(HB_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_NEED = SW'(STABLE_CYCLES - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(PULSE_BEATS - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIMEOUT - 1);
    localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    logic [HW-1:0] hb_cnt;
    logic          hb_rise;
    logic          mclk_s1, mclk_s2, mclk_d, mclk_rise;
    logic [7:0]    emo_s1, emo_s2, emo_prev;
    logic [SW-1:0] stab_cnt;
    logic [DW-1:0] dead_cnt;
    logic          dead_set;
    state_e        state;
    logic [BW-1:0] beat_cnt;
    logic          abort, accept;

    // High in the cycle before heartbeat goes 0 -> 1.
    assign hb_rise = hb_en && (hb_cnt == HB_LAST) && !heartbeat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (!hb_en) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mclk_s1  <= 1'b0;
            mclk_s2  <= 1'b0;
            mclk_d   <= 1'b0;
            emo_s1   <= '0;
            emo_s2   <= '0;
            emo_prev <= '0;
        end else begin
            mclk_s1  <= model_clk_in;
            mclk_s2  <= mclk_s1;
            mclk_d   <= mclk_s2;
            emo_s1   <= emotion_in;
            emo_s2   <= emo_s1;
            emo_prev <= emo_s2;
        end
    end

    assign mclk_rise = mclk_s2 && !mclk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt    <= '0;
            emotion_out <= '0;
            emotion_evt <= 1'b0;
        end else begin
            emotion_evt <= 1'b0;
            if (emo_s2 != emo_prev) begin
                stab_cnt <= '0;
            end else begin
                if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 1'b1;
                if (stab_cnt >= STAB_NEED && emo_s2 != emotion_out) begin
                    emotion_out <= emo_s2;
                    emotion_evt <= 1'b1;
                end
            end
        end
    end

    // A model-clock edge in the same cycle as a heartbeat edge keeps the core alive.
    assign dead_set = hb_rise && !mclk_rise && (dead_cnt == DEAD_LAST) && !dead_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_cnt <= '0;
            dead_out <= 1'b0;
        end else begin
            if (hb_en) begin
                if (mclk_rise) dead_cnt <= '0;
                else if (hb_rise && dead_cnt != DEAD_MAX) dead_cnt <= dead_cnt + 1'b1;
            end
            if (dead_set) dead_out <= 1'b1;
        end
    end

    assign abort     = !hb_en || dead_out || dead_set;
    assign accept    = stim_req && (stim_code != 7'd0) && !abort;
    assign stim_busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            beat_cnt <= '0;
            stim_out <= '0;
            stim_ack <= 1'b0;
        end else begin
            stim_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        state    <= StHold;
                        stim_out <= stim_code;
                        stim_ack <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                StHold: begin
                    if (abort) begin
                        state    <= StIdle;
                        stim_out <= '0;
                    end else if (mclk_rise) begin
                        if (beat_cnt == BEAT_LAST) begin
                            state    <= StGap;
                            stim_out <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (abort || mclk_rise) state <= StIdle;
                end
                default: begin
                    state    <= StIdle;
                    stim_out <= '0;
                end
            endcase
        end
    end

endmodule
